// File: rtl/maxpool_col_buf.sv
// Row-to-column reorder buffer: collects R raster rows per block into one of two ping-pong banks,
// then emits the block one R-pixel column per beat for the downstream max-pool stage.
module maxpool_col_buf #(
  parameter int unsigned R    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [W-1:0]          s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [R-1:0][W-1:0]   m_data_o
);

  localparam int unsigned RW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] RowLast = RW'(R - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);

  logic [W-1:0]  mem_q [2][R][COLS];

  logic          wb_q, wb_d;
  logic [RW-1:0] wr_q, wr_d;
  logic [CW-1:0] wc_q, wc_d;
  logic          rb_q, rb_d;
  logic [CW-1:0] rc_q, rc_d;
  logic [1:0]    full_q, full_d;

  logic s_acc, m_acc;

  // Handshakes depend only on registered state; no m_ready -> s_ready path exists.
  assign s_ready_o = ~full_q[wb_q];
  assign m_valid_o = full_q[rb_q];
  assign s_acc     = s_valid_i & s_ready_o;
  assign m_acc     = m_valid_o & m_ready_i;

  always_comb begin
    m_data_o = '0;
    for (int unsigned r = 0; r < R; r++) begin
      if (m_valid_o) m_data_o[r] = mem_q[rb_q][r][rc_q];
    end
  end

  // Write and read banks never coincide, so setting and clearing full bits cannot collide.
  always_comb begin
    wb_d   = wb_q;
    wr_d   = wr_q;
    wc_d   = wc_q;
    rb_d   = rb_q;
    rc_d   = rc_q;
    full_d = full_q;
    if (s_acc) begin
      if (wc_q == ColLast) begin
        wc_d = '0;
        if (wr_q == RowLast) begin
          wr_d         = '0;
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
        end else begin
          wr_d = wr_q + RW'(1);
        end
      end else begin
        wc_d = wc_q + CW'(1);
      end
    end
    if (m_acc) begin
      if (rc_q == ColLast) begin
        rc_d         = '0;
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end else begin
        rc_d = rc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q   <= 1'b0;
      wr_q   <= '0;
      wc_q   <= '0;
      rb_q   <= 1'b0;
      rc_q   <= '0;
      full_q <= 2'b00;
    end else begin
      wb_q   <= wb_d;
      wr_q   <= wr_d;
      wc_q   <= wc_d;
      rb_q   <= rb_d;
      rc_q   <= rc_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_acc && !rst_i) mem_q[wb_q][wr_q][wc_q] <= s_data_i;
  end

endmodule
